// File: rtl/riscv_pipe_pkg.sv
// Shared types for the five-stage core's inter-stage latches.
// Each stage payload is a packed struct, so a stage register is sized with
// DATA_W = $bits(<stage>_t).
package riscv_pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
  } mem_wb_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage register: the upstream valid/ready/data,
// the downstream valid/ready/data, the flush input and the stall counter output.
// slave is the stage register side and master is the surrounding pipeline side.
interface pipe_stage_reg_if #(
  parameter int DATA_W = riscv_pipe_pkg::DEF_DATA_W,
  parameter int CNT_W  = riscv_pipe_pkg::DEF_CNT_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, stall_cnt
  );

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: an up-counter with an increment enable. It stops at all-ones
// and does not wrap. Only the asynchronous active-low reset clears it.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] cnt
);
  // Count enabled cycles and hold once the all-ones value is reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 cnt <= '0;
    else if (en && (cnt != '1)) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: a generic valid/ready pipeline latch with flush and a
// saturating count of stalled cycles.
// Define PIPE_SKID_EN to add a second (skid) entry. In that mode in_ready
// comes from a register, so no combinational ready path runs through the stage.
module pipe_stage_reg
  import riscv_pipe_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                CNT_W      = DEF_CNT_W,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stage_reg_if.slave   bus
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              up_xfer;
  logic              dn_xfer;

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign up_xfer       = bus.in_valid && bus.in_ready;
  assign dn_xfer       = valid_q && bus.out_ready;

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              rdy_q;

  // The ready register is low during reset, so upstream sees no ready until
  // the first edge after reset is released.
  assign bus.in_ready = rdy_q && !bus.flush;

  // Main entry plus skid entry, kept in FIFO order. While skid is full,
  // in_ready is low, so skid never loads in the same cycle that it drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      data_q     <= RESET_DATA;
      skid_valid <= 1'b0;
      skid_data  <= RESET_DATA;
      rdy_q      <= 1'b0;
    end else if (bus.flush) begin
      valid_q    <= 1'b0;
      skid_valid <= 1'b0;
      rdy_q      <= 1'b1;
    end else if (!valid_q || dn_xfer) begin
      if (skid_valid) begin
        data_q     <= skid_data;
        valid_q    <= 1'b1;
        skid_valid <= 1'b0;
      end else if (up_xfer) begin
        data_q  <= bus.in_data;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
      rdy_q <= 1'b1;
    end else if (up_xfer) begin
      skid_data  <= bus.in_data;
      skid_valid <= 1'b1;
      rdy_q      <= 1'b0;
    end
  end
`else
  // With one entry, the stage accepts data when it is empty or is draining this cycle.
  assign bus.in_ready = !bus.flush && (!valid_q || bus.out_ready);

  // Single-entry latch. Flush clears only the valid bit, and the data
  // register changes only on a load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_DATA;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (up_xfer) begin
      data_q  <= bus.in_data;
      valid_q <= 1'b1;
    end else if (dn_xfer) begin
      valid_q <= 1'b0;
    end
  end
`endif

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (valid_q && !bus.out_ready && !bus.flush),
    .cnt   (bus.stall_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. It runs a vector table, then hand
// sequences for stall and skid order, counter saturation on a narrow
// instance, and asynchronous reset.
module tb_pipe_stage_reg;
  import riscv_pipe_pkg::*;

`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [31:0] RST_D = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(32), .CNT_W(16)) bus  ();
  pipe_stage_reg_if #(.DATA_W(32), .CNT_W(3))  bus2 ();

  pipe_stage_reg #(.DATA_W(32), .CNT_W(16), .RESET_DATA(RST_D)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  pipe_stage_reg #(.DATA_W(32), .CNT_W(3), .RESET_DATA(RST_D)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        e_rdy;   // in_ready expected before the edge
    logic        e_ov;    // expected after the edge
    logic [31:0] e_od;
    logic [15:0] e_sc;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 0; bus.in_data = '0; bus.flush = 0; bus.out_ready = 0;
    bus2.in_valid = 0; bus2.in_data = '0; bus2.flush = 0; bus2.out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, RST_D);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    reset = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    logic acc;
    //         iv  d            ordy fl  rdy ov  od           sc
    vt[0] = '{1, 32'h0000_00A5, 1, 0,  1, 1, 32'h0000_00A5, 0};
    vt[1] = '{1, 32'h1,         1, 0,  1, 1, 32'h1,         0};
    vt[2] = '{1, 32'h2,         1, 0,  1, 1, 32'h2,         0};
    vt[3] = '{1, 32'h3,         1, 0,  1, 1, 32'h3,         0};
    vt[4] = '{1, 32'h4,         1, 0,  1, 1, 32'h4,         0};
    vt[5] = '{0, 32'h0,         1, 0,  1, 0, 32'h4,         0};
    vt[6] = '{1, 32'h55,        0, 0,  1, 1, 32'h55,        0};
    vt[7] = '{1, 32'h33,        0, 1,  0, 0, 32'h55,        0};
    vt[8] = '{0, 32'h0,         1, 0,  1, 0, 32'h55,        0};

    // Vector table: first transfer, back-to-back stream, drain, flush.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.in_valid = vt[i].iv; bus.in_data = vt[i].d;
      bus.out_ready = vt[i].ordy; bus.flush = vt[i].fl;
      #1 chk($sformatf("v%0d_in_ready", i), bus.in_ready, vt[i].e_rdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), bus.out_valid, vt[i].e_ov);
      chk($sformatf("v%0d_out_data", i), bus.out_data, vt[i].e_od);
      chk($sformatf("v%0d_stall_cnt", i), bus.stall_cnt, vt[i].e_sc);
    end

    // Stall for 5 cycles while 0x22 waits upstream. In skid mode 0x22 goes to skid.
    do_reset();
    @(negedge clk);
    bus.in_valid = 1; bus.in_data = 32'h11; bus.out_ready = 1;
    @(posedge clk); #1;
    chk("st_load_valid", bus.out_valid, 1);
    chk("st_load_data", bus.out_data, 32'h11);
    @(negedge clk);
    bus.in_data = 32'h22; bus.out_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      #1 chk($sformatf("st%0d_in_ready", i), bus.in_ready, (i == 1) ? SKID : 1'b0);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      chk($sformatf("st%0d_out_data", i), bus.out_data, 32'h11);
      chk($sformatf("st%0d_out_valid", i), bus.out_valid, 1);
      chk($sformatf("st%0d_stall_cnt", i), bus.stall_cnt, i);
      @(negedge clk);
      if (acc) bus.in_valid = 0;
    end
    bus.out_ready = 1;
    #1 chk("st_rel_in_ready", bus.in_ready, SKID ? 1'b0 : 1'b1);
    acc = bus.in_valid && bus.in_ready;
    @(posedge clk); #1;
    chk("st_second_valid", bus.out_valid, 1);
    chk("st_second_data", bus.out_data, 32'h22);
    chk("st_cnt_hold", bus.stall_cnt, 5);
    @(negedge clk);
    if (acc) bus.in_valid = 0;
    @(posedge clk); #1;
    chk("st_drained", bus.out_valid, 0);
    chk("st_in_ready_after", bus.in_ready, 1);

    // Saturation of the 3-bit counter.
    do_reset();
    @(negedge clk);
    bus2.in_valid = 1; bus2.in_data = 32'h7; bus2.out_ready = 0;
    @(posedge clk); #1;
    chk("sat_loaded", bus2.out_valid, 1);
    chk("sat_cnt0", bus2.stall_cnt, 0);
    @(negedge clk);
    bus2.in_valid = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("sat_cnt%0d", i), bus2.stall_cnt, (i > 7) ? 7 : i);
    end
    chk("sat_data_held", bus2.out_data, 32'h7);

    // Asynchronous reset between clock edges.
    do_reset();
    @(negedge clk);
    bus.in_valid = 1; bus.in_data = 32'h44; bus.out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 0;
    @(posedge clk); #1;
    chk("ar_pre_valid", bus.out_valid, 1);
    chk("ar_pre_cnt", bus.stall_cnt, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_out_valid", bus.out_valid, 0);
    chk("ar_stall_cnt", bus.stall_cnt, 0);
    chk("ar_out_data", bus.out_data, RST_D);
    chk("ar_in_ready", bus.in_ready, SKID ? 1'b0 : 1'b1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that generalises the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) of the five-stage RISC-V core into one reusable block. It carries an arbitrary-width payload bus with a valid/ready handshake, a flush for branch/jump squash, and a saturating stall-cycle counter for performance monitoring. An optional skid buffer registers the upstream ready path so that long stall chains do not form a combinational path.

## Interface
Parameters:
- DATA_W, 32: payload width in bits, ≥1; the stage's control and data fields are packed into it.
- CNT_W, 16: stall counter width, ≥1.
- RESET_DATA, '0: payload register reset value, DATA_W bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds a valid payload.
- in_ready  out  1  stage accepts the payload this cycle.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  squash all held payloads (branch taken / exception).
- out_valid  out  1  stage presents a valid payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  held payload.
- stall_cnt  out  CNT_W  saturating count of downstream-stalled cycles.

## Operation
- Upstream transfer when in_valid && in_ready. Downstream transfer when out_valid && out_ready.
- Base mode, one entry: in_ready = flush ? 0 : (!valid_q || out_ready), combinational. On an upstream transfer, data_q ← in_data and valid_q ← 1. On a downstream transfer with no upstream transfer, valid_q ← 0.
- out_valid = valid_q; out_data = data_q. data_q changes only on a load and is not cleared by a flush or a drain.
- flush has top priority: next cycle every valid bit is 0, in_data is dropped, and in_ready is 0 during the flush cycle. Data registers keep their contents.
- Stall counter: increments when out_valid && !out_ready && !flush. It saturates at 2^CNT_W−1 and does not wrap. Only reset clears it.
- Protocol rules for neighbours: after asserting in_valid, upstream holds in_valid and in_data stable until the transfer or a flush. The block keeps out_valid and out_data stable while out_ready is low.

## Timing
- Reset (asynchronous assert, synchronous release): out_valid=0, out_data=RESET_DATA, stall_cnt=0. In base mode in_ready=1 once reset is released and flush is low; in skid mode in_ready=0 while reset is asserted.
- Latency: one cycle from an upstream transfer to out_valid.
- Throughput: one transfer per cycle with out_ready held high. Simultaneous input and output transfer in the same cycle leaves valid_q at 1 and loads the new data.
- Reset asserted mid-transfer: the payload is lost and outputs take their reset values immediately.

## Configuration
- PIPE_SKID_EN defined: two entries (main and skid).
  - in_ready is a register, = !skid_valid, forced to 0 during flush.
  - If the stage takes an upstream transfer while main is full and out_ready is low, the payload goes to skid.
  - When main drains, skid moves to main in the same cycle.
  - Ordering is FIFO; no payload is duplicated or lost.
  - Latency stays 1 cycle; in_ready deasserts one cycle after the stall.
- PIPE_SKID_EN undefined: single-entry base mode as described above; the skid registers do not exist.

## Structure
- Shared package riscv_pipe_pkg:
  - packed struct typedefs for each stage payload (ex_mem_t, etc.) so that DATA_W = $bits(...);
  - localparam defaults for DATA_W and CNT_W.
- One sub-module, sat_counter (width-parametrised, increment enable, saturation), used for stall_cnt.
- The skid logic stays inline and is guarded by the macro.

## Test plan
- Reset release, then in_valid=1, in_data=0x0000_00A5, out_ready=1 → out_valid=1 and out_data=0xA5 in the next cycle; in_ready stays 1.
- Back-to-back stream 1,2,3,4 with out_ready=1 → outputs 1,2,3,4 on consecutive cycles, no bubbles.
- Load 0x11, hold out_ready=0 for 5 cycles → out_data stays 0x11, stall_cnt=5. Base mode: in_ready=0 during the stall. Skid mode: 0x22 is accepted into skid, then in_ready=0. After release, 0x11 then 0x22 come out in order.
- flush with valid_q=1 and in_valid=1 (0x33) in the same cycle → out_valid=0 in the next cycle and 0x33 never appears at the output.
- CNT_W=3, keep out_ready=0 for 10 cycles → stall_cnt goes 1..7 and holds at 7.
- Assert reset mid-stream (asynchronous, between clock edges) → out_valid=0 and stall_cnt=0 immediately, out_data=RESET_DATA.
